// File: rtl/dmux8_reg.sv
// 1-to-8 demultiplexer: routes d0 to the output picked by {s2,s1,s0}, zeros elsewhere.
// Optional output register stage; REGISTERED=0 gives a purely combinational path.
module dmux8_reg #(
   parameter int unsigned DATA_W     = 1,
   parameter bit          REGISTERED = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              s0,
   input  logic              s1,
   input  logic              s2,
   input  logic [DATA_W-1:0] d0,
   output logic [DATA_W-1:0] z0,
   output logic [DATA_W-1:0] z1,
   output logic [DATA_W-1:0] z2,
   output logic [DATA_W-1:0] z3,
   output logic [DATA_W-1:0] z4,
   output logic [DATA_W-1:0] z5,
   output logic [DATA_W-1:0] z6,
   output logic [DATA_W-1:0] z7
);

   logic [2:0]        sel;
   logic [DATA_W-1:0] z_next [8];
   logic [DATA_W-1:0] z_out  [8];

   assign sel = {s2, s1, s0};

   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         z_next[i] = (sel == 3'(i)) ? d0 : '0;
      end
   end

   if (REGISTERED) begin : g_reg
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int unsigned i = 0; i < 8; i++) begin
               z_out[i] <= '0;
            end
         end else begin
            z_out <= z_next;
         end
      end
   end else begin : g_comb
      // Reset still gates the outputs in the combinational build; clk is unused here.
      logic unused_clk;
      assign unused_clk = clk;

      always_comb begin
         for (int unsigned i = 0; i < 8; i++) begin
            z_out[i] = rstn ? z_next[i] : '0;
         end
      end
   end

   assign z0 = z_out[0];
   assign z1 = z_out[1];
   assign z2 = z_out[2];
   assign z3 = z_out[3];
   assign z4 = z_out[4];
   assign z5 = z_out[5];
   assign z6 = z_out[6];
   assign z7 = z_out[7];

endmodule

// File: tb/tb_dmux8_reg.sv
// Directed bench for dmux8_reg: registered 1-bit, combinational 1-bit and registered 4-bit builds.
module tb_dmux8_reg;

   logic       clk;
   logic       rstn;
   logic [2:0] s;
   logic       d;
   logic [3:0] d4;

   logic r0, r1, r2, r3, r4, r5, r6, r7;
   logic c0, c1, c2, c3, c4, c5, c6, c7;
   logic [3:0] w0, w1, w2, w3, w4, w5, w6, w7;

   int unsigned n_vec;
   int unsigned n_bad;

   dmux8_reg #(.DATA_W(1), .REGISTERED(1'b1)) u_reg (
      .clk(clk), .rstn(rstn), .s0(s[0]), .s1(s[1]), .s2(s[2]), .d0(d),
      .z0(r0), .z1(r1), .z2(r2), .z3(r3), .z4(r4), .z5(r5), .z6(r6), .z7(r7)
   );

   dmux8_reg #(.DATA_W(1), .REGISTERED(1'b0)) u_comb (
      .clk(clk), .rstn(rstn), .s0(s[0]), .s1(s[1]), .s2(s[2]), .d0(d),
      .z0(c0), .z1(c1), .z2(c2), .z3(c3), .z4(c4), .z5(c5), .z6(c6), .z7(c7)
   );

   dmux8_reg #(.DATA_W(4), .REGISTERED(1'b1)) u_wide (
      .clk(clk), .rstn(rstn), .s0(s[0]), .s1(s[1]), .s2(s[2]), .d0(d4),
      .z0(w0), .z1(w1), .z2(w2), .z3(w3), .z4(w4), .z5(w5), .z6(w6), .z7(w7)
   );

   wire [7:0]  reg_v  = {r7, r6, r5, r4, r3, r2, r1, r0};
   wire [7:0]  comb_v = {c7, c6, c5, c4, c3, c2, c1, c0};
   wire [31:0] wide_v = {w7, w6, w5, w4, w3, w2, w1, w0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] onehot(input logic [2:0] sel, input logic bit_in);
      logic [31:0] v;
      v = '0;
      v[sel] = bit_in;
      return v;
   endfunction

   function automatic logic [31:0] nib(input logic [2:0] sel, input logic [3:0] val);
      logic [31:0] v;
      v = {28'h0, val};
      return v << (4 * sel);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_bad = 0;

      // Reset held with sel=3, d=1 while clocks run
      rstn = 1'b0; s = 3'd3; d = 1'b1; d4 = 4'h5;
      tick(); tick();
      chk("rst_reg",  32'(reg_v),  32'h0);
      chk("rst_comb", 32'(comb_v), 32'h0);
      chk("rst_wide", wide_v,      32'h0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("rel_comb", 32'(comb_v), onehot(3'd3, 1'b1));
      chk("rel_reg_pre", 32'(reg_v), 32'h0);
      tick();
      chk("rel_reg",  32'(reg_v),  32'h08);
      chk("rel_wide", wide_v,      32'h0000_5000);

      // Sweep every select with d=0 then d=1
      for (int sv = 0; sv < 8; sv++) begin
         for (int dv = 0; dv < 2; dv++) begin
            @(negedge clk);
            s  = 3'(sv);
            d  = dv[0];
            d4 = dv[0] ? 4'hF - 4'(sv) : 4'h0;
            #1;
            chk("sweep_comb", 32'(comb_v), onehot(s, d));
            tick();
            chk("sweep_reg",  32'(reg_v),  onehot(s, d));
            chk("sweep_wide", wide_v,      nib(s, d4));
         end
      end

      // Select changes between edges: register holds until the next edge
      @(negedge clk);
      s = 3'd2; d = 1'b1;
      tick();
      chk("lat_z2", 32'(reg_v), 32'h04);
      #2;
      s = 3'd5;
      #1;
      chk("lat_hold", 32'(reg_v), 32'h04);
      chk("lat_comb", 32'(comb_v), 32'h20);
      tick();
      chk("lat_z5", 32'(reg_v), 32'h20);

      // Asynchronous reset between edges
      @(negedge clk);
      s = 3'd7; d = 1'b1; d4 = 4'h9;
      tick();
      chk("pre_async", 32'(reg_v), 32'h80);
      chk("pre_async_wide", wide_v, 32'h9000_0000);
      #2;
      rstn = 1'b0;
      #1;
      chk("async_reg",  32'(reg_v),  32'h0);
      chk("async_wide", wide_v,      32'h0);
      chk("async_comb", 32'(comb_v), 32'h0);
      tick();
      chk("async_hold", 32'(reg_v), 32'h0);

      // Combinational build: same-timestep response and reset gating
      @(negedge clk);
      rstn = 1'b1; s = 3'd6; d = 1'b1;
      #1;
      chk("comb_z6", 32'(comb_v), 32'h40);
      rstn = 1'b0;
      #1;
      chk("comb_rst", 32'(comb_v), 32'h0);
      rstn = 1'b1;

      // Wide build: 4'hA on z1, then zero data
      @(negedge clk);
      s = 3'd1; d4 = 4'hA; d = 1'b0;
      tick();
      chk("wide_a",   wide_v,      32'h0000_00A0);
      chk("d0_zero",  32'(reg_v),  32'h0);
      @(negedge clk);
      d4 = 4'h0;
      tick();
      chk("wide_zero", wide_v, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
